alu_core: RTL and testbench



---
 rtl/alu_core_pkg.sv | 19 +
 rtl/alu_core_comb.sv | 51 +++++
 rtl/alu_core.sv | 69 ++++++
 tb/tb_alu_core.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_core_pkg.sv
// alu_core_pkg: opcode enum and flag bundle for the alu_core slice.
// Flag bundle is only consumed when ALU_CORE_FLAGS_EN is defined.
package alu_core_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_core_comb.sv
// alu_core_comb: combinational ADD/SUB/AND/OR datapath, modulo 2^WIDTH.
// Flags output exists only when ALU_CORE_FLAGS_EN is defined.
import alu_core_pkg::*;

module alu_core_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] res
`ifdef ALU_CORE_FLAGS_EN
  ,
  output alu_flags_t       flags
`endif
);

  // Operation select; carry/borrow fall off the top.
  always_comb begin
    res = '0;
    unique case (op)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
    endcase
  end

`ifdef ALU_CORE_FLAGS_EN
  localparam int M = WIDTH - 1;

  // Wrapped sum below A means a carry-out occurred.
  always_comb begin
    flags   = '0;
    flags.z = (res == '0);
    flags.n = res[M];
    unique case (op)
      ALU_ADD: begin
        flags.c = (res < a);
        flags.v = (a[M] == b[M]) && (res[M] != a[M]);
      end
      ALU_SUB: begin
        flags.c = (a < b);
        flags.v = (a[M] != b[M]) && (res[M] != a[M]);
      end
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/alu_core.sv
// alu_core: registered ALU, one-cycle latency, async active-low reset.
// Define ALU_CORE_FLAGS_EN to add registered z/n/c/v flag outputs.
import alu_core_pkg::*;

module alu_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ALUop,
  output logic [WIDTH-1:0] Result,
  output logic             out_valid
`ifdef ALU_CORE_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
`endif
);

  logic [WIDTH-1:0] res;

`ifdef ALU_CORE_FLAGS_EN
  alu_flags_t flags;
  alu_flags_t flags_q;
`endif

  alu_core_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .a    (A),
    .b    (B),
    .op   (alu_op_e'(ALUop)),
    .res  (res)
`ifdef ALU_CORE_FLAGS_EN
    ,
    .flags(flags)
`endif
  );

  // Capture result on valid; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) Result <= res;
    end
  end

`ifdef ALU_CORE_FLAGS_EN
  // Flags follow the same capture rule as Result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else if (in_valid) flags_q <= flags;
  end

  assign flag_z = flags_q.z;
  assign flag_n = flags_q.n;
  assign flag_c = flags_q.c;
  assign flag_v = flags_q.v;
`endif

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed + random checks of alu_core (WIDTH 4 and 8).
// Flag checks active when ALU_CORE_FLAGS_EN is defined.
module tb_alu_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a, b;
  logic [1:0] alu_op;
  logic [3:0] result;
  logic       out_valid;

  logic       in_valid8;
  logic [7:0] a8, b8;
  logic [1:0] alu_op8;
  logic [7:0] result8;
  logic       out_valid8;

  int vecs = 0;
  int errs = 0;

`ifdef ALU_CORE_FLAGS_EN
  logic fz, fn, fc, fv;
  logic fz8, fn8, fc8, fv8;
`endif

  always #5 clk = ~clk;

  alu_core #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (a),
    .B        (b),
    .ALUop    (alu_op),
    .Result   (result),
    .out_valid(out_valid)
`ifdef ALU_CORE_FLAGS_EN
    ,
    .flag_z   (fz),
    .flag_n   (fn),
    .flag_c   (fc),
    .flag_v   (fv)
`endif
  );

  alu_core #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .A        (a8),
    .B        (b8),
    .ALUop    (alu_op8),
    .Result   (result8),
    .out_valid(out_valid8)
`ifdef ALU_CORE_FLAGS_EN
    ,
    .flag_z   (fz8),
    .flag_n   (fn8),
    .flag_c   (fc8),
    .flag_v   (fv8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input int w, input logic [1:0] op,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    logic [63:0] r;
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case (op)
      2'b00:   r = {32'd0, x} + {32'd0, y};
      2'b01:   r = {32'd0, x} - {32'd0, y};
      2'b10:   r = {32'd0, x & y};
      default: r = {32'd0, x | y};
    endcase
    return r[31:0] & m[31:0];
  endfunction

  // Reference flags {z,n,c,v} using integer arithmetic.
  function automatic logic [3:0] ref_flags(input int w, input logic [1:0] op,
                                           input int x, input int y);
    int r, sx, sy, s, half, full;
    logic z, n, c, v;
    full = 1 << w;
    half = full / 2;
    r  = int'(ref_op(w, op, x, y));
    sx = (x >= half) ? x - full : x;
    sy = (y >= half) ? y - full : y;
    z  = (r == 0);
    n  = (r >= half);
    c  = 1'b0;
    v  = 1'b0;
    if (op == 2'b00) begin
      c = (x + y) >= full;
      s = sx + sy;
      v = (s >= half) || (s < -half);
    end else if (op == 2'b01) begin
      c = x < y;
      s = sx - sy;
      v = (s >= half) || (s < -half);
    end
    return {z, n, c, v};
  endfunction

  task automatic step(input logic v, input logic [3:0] x, input logic [3:0] y,
                      input logic [1:0] op, input string tag,
                      input logic [3:0] exp_r, input logic exp_v);
    in_valid = v;
    a        = x;
    b        = y;
    alu_op   = op;
    @(posedge clk);
    #1;
    chk({tag, ".res"}, 32'(result), 32'(exp_r));
    chk({tag, ".vld"}, 32'(out_valid), 32'(exp_v));
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] exp);
`ifdef ALU_CORE_FLAGS_EN
    chk({tag, ".flg"}, 32'({fz, fn, fc, fv}), 32'(exp));
`else
    if (exp === 4'bxxxx) chk({tag, ".flg"}, 32'(exp), 32'(result));
`endif
  endtask

  logic [3:0]  exp4;
  logic [7:0]  exp8;
  logic [3:0]  expf4, expf8;
  logic        ev4, ev8;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a         = 4'b0100;
    b         = 4'b0001;
    alu_op    = 2'b00;
    in_valid8 = 1'b0;
    a8        = '0;
    b8        = '0;
    alu_op8   = '0;

    // Reset held with valid inputs present.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst.res", 32'(result), 32'd0);
      chk("rst.vld", 32'(out_valid), 32'd0);
    end
    chk_flags("rst", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.res", 32'(result), 32'd0);
    chk("rel.vld", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("first.res", 32'(result), 32'h5);
    chk("first.vld", 32'(out_valid), 32'd1);

    // Opcode sweep.
    step(1, 4'b0100, 4'b0001, 2'b11, "or",  4'b0101, 1);
    step(1, 4'b0100, 4'b0001, 2'b10, "and", 4'b0000, 1);
    step(1, 4'b0100, 4'b0001, 2'b01, "sub", 4'b0011, 1);
    step(1, 4'b0100, 4'b0001, 2'b00, "add", 4'b0101, 1);

    // Wrap-around; flags {z,n,c,v}.
    step(1, 4'b1111, 4'b0001, 2'b00, "wadd", 4'b0000, 1);
    chk_flags("wadd", 4'b1010);
    step(1, 4'b0000, 4'b0001, 2'b01, "wsub", 4'b1111, 1);
    chk_flags("wsub", 4'b0110);
    step(1, 4'b0111, 4'b0001, 2'b00, "vadd", 4'b1000, 1);
    chk_flags("vadd", 4'b0101);

    // Hold with idle random inputs.
    step(1, 4'b0010, 4'b0011, 2'b00, "hadd", 4'b0101, 1);
    for (int i = 0; i < 3; i++)
      step(0, 4'($urandom), 4'($urandom), 2'($urandom), "hold", 4'b0101, 0);
    chk_flags("hold", 4'b0000);

    // Async reset pulse between edges.
    step(1, 4'b0001, 4'b0001, 2'b00, "pre", 4'b0010, 1);
    a = 4'b0011;
    b = 4'b0011;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.res", 32'(result), 32'd0);
    chk("arst.vld", 32'(out_valid), 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post.res", 32'(result), 32'h6);
    chk("post.vld", 32'(out_valid), 32'd1);

    // Random, both widths, against reference model.
    exp4 = result;
    exp8 = result8;
    expf4 = 4'b0000;
    expf8 = 4'b0000;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      a         = 4'($urandom);
      b         = 4'($urandom);
      alu_op    = 2'($urandom);
      in_valid8 = 1'($urandom_range(0, 3) != 0);
      a8        = 8'($urandom);
      b8        = 8'($urandom);
      alu_op8   = 2'($urandom);
      ev4 = in_valid;
      ev8 = in_valid8;
      if (in_valid) begin
        exp4  = 4'(ref_op(4, alu_op, 32'(a), 32'(b)));
        expf4 = ref_flags(4, alu_op, int'(a), int'(b));
      end
      if (in_valid8) begin
        exp8  = 8'(ref_op(8, alu_op8, 32'(a8), 32'(b8)));
        expf8 = ref_flags(8, alu_op8, int'(a8), int'(b8));
      end
      @(posedge clk);
      #1;
      chk("rnd4.res", 32'(result), 32'(exp4));
      chk("rnd4.vld", 32'(out_valid), 32'(ev4));
      chk("rnd8.res", 32'(result8), 32'(exp8));
      chk("rnd8.vld", 32'(out_valid8), 32'(ev8));
`ifdef ALU_CORE_FLAGS_EN
      chk("rnd4.flg", 32'({fz, fn, fc, fv}), 32'(expf4));
      chk("rnd8.flg", 32'({fz8, fn8, fc8, fv8}), 32'(expf8));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
